// File: rtl/alu_exec_unit.sv
// Multi-cycle ALU execute stage: ADD/SUB/OR in a fixed two cycles, SLL on a 1-bit/cycle shifter.
// Define ALU_OVERFLOW_EN to add the signed-overflow flag (overflow_o) for ADD/SUB.
module alu_exec_unit #(
    parameter int DATA_WIDTH  = 32,
    parameter int SHAMT_WIDTH = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_i,
    input  logic [3:0]             alu_operation_i,
    input  logic [DATA_WIDTH-1:0]  a_data_i,
    input  logic [DATA_WIDTH-1:0]  b_data_i,
    input  logic [SHAMT_WIDTH-1:0] shamt_i,
    output logic                   busy_o,
    output logic                   done_o,
    output logic [DATA_WIDTH-1:0]  alu_data_o,
    output logic                   zero_o,
    output logic                   illegal_op_o
`ifdef ALU_OVERFLOW_EN
    ,
    output logic                   overflow_o
`endif
);

    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_SLL = 4'b0010;
    localparam logic [3:0] OP_ADD = 4'b0011;
    localparam logic [3:0] OP_SUB = 4'b0100;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_EXEC  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]             op_q;
    logic [DATA_WIDTH-1:0]  a_q;
    logic [DATA_WIDTH-1:0]  b_q;
    logic [SHAMT_WIDTH-1:0] cnt_q;
    logic [DATA_WIDTH-1:0]  res_q;
    logic                   ill_q;

    logic [DATA_WIDTH-1:0]  sum;
    logic [DATA_WIDTH-1:0]  diff;
    logic [DATA_WIDTH-1:0]  exec_result;
    logic                   exec_illegal;

    assign busy_o = (state != ST_IDLE);
    assign sum    = a_q + b_q;
    assign diff   = a_q - b_q;

    // ---------------- state register ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: begin
                if (start_i) begin
                    state_next = (alu_operation_i == OP_SLL) ? ST_SHIFT : ST_EXEC;
                end
            end
            ST_EXEC:  state_next = ST_DONE;
            ST_SHIFT: begin
                if (cnt_q == '0) begin
                    state_next = ST_DONE;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // ---------------- single-cycle operations ----------------
    always_comb begin
        exec_result  = '0;
        exec_illegal = 1'b0;
        case (op_q)
            OP_ADD:  exec_result = sum;
            OP_SUB:  exec_result = diff;
            OP_OR:   exec_result = a_q | b_q;
            default: exec_illegal = 1'b1;
        endcase
    end

`ifdef ALU_OVERFLOW_EN
    logic ovf_q;
    logic exec_overflow;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB) and the result sign flips.
    always_comb begin
        exec_overflow = 1'b0;
        case (op_q)
            OP_ADD: exec_overflow = (a_q[DATA_WIDTH-1] == b_q[DATA_WIDTH-1]) &&
                                    (sum[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
            OP_SUB: exec_overflow = (a_q[DATA_WIDTH-1] != b_q[DATA_WIDTH-1]) &&
                                    (diff[DATA_WIDTH-1] != a_q[DATA_WIDTH-1]);
            default: exec_overflow = 1'b0;
        endcase
    end
`endif

    // ---------------- operand latch and working result ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            op_q  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
            res_q <= '0;
            ill_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            ovf_q <= 1'b0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_i) begin
                        op_q  <= alu_operation_i;
                        a_q   <= a_data_i;
                        b_q   <= b_data_i;
                        cnt_q <= shamt_i;
                        // res_q doubles as the shift accumulator for SLL.
                        res_q <= b_data_i;
                        ill_q <= 1'b0;
`ifdef ALU_OVERFLOW_EN
                        ovf_q <= 1'b0;
`endif
                    end
                end
                ST_EXEC: begin
                    res_q <= exec_result;
                    ill_q <= exec_illegal;
`ifdef ALU_OVERFLOW_EN
                    ovf_q <= exec_overflow;
`endif
                end
                ST_SHIFT: begin
                    if (cnt_q != '0) begin
                        res_q <= {res_q[DATA_WIDTH-2:0], 1'b0};
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ---------------- registered outputs, refreshed only on completion ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            done_o       <= 1'b0;
            alu_data_o   <= '0;
            zero_o       <= 1'b1;
            illegal_op_o <= 1'b0;
`ifdef ALU_OVERFLOW_EN
            overflow_o   <= 1'b0;
`endif
        end else begin
            done_o <= (state == ST_DONE);
            if (state == ST_DONE) begin
                alu_data_o   <= res_q;
                zero_o       <= (res_q == '0);
                illegal_op_o <= ill_q;
`ifdef ALU_OVERFLOW_EN
                overflow_o   <= ovf_q;
`endif
            end
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Bench for alu_exec_unit: directed cases with literal expectations plus random traffic
// compared every cycle against a transaction-level model (result queue + latency countdown).
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_SLL = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b1;
  logic         start_i = 1'b0;
  logic [3:0]   alu_operation_i = '0;
  logic [W-1:0] a_data_i = '0;
  logic [W-1:0] b_data_i = '0;
  logic [4:0]   shamt_i = '0;
  logic         busy_o, done_o, zero_o, illegal_op_o;
  logic [W-1:0] alu_data_o;
`ifdef ALU_OVERFLOW_EN
  logic         overflow_o;
`endif

  alu_exec_unit #(.DATA_WIDTH(W), .SHAMT_WIDTH(5)) dut (
    .clk(clk),
    .reset(reset),
    .start_i(start_i),
    .alu_operation_i(alu_operation_i),
    .a_data_i(a_data_i),
    .b_data_i(b_data_i),
    .shamt_i(shamt_i),
    .busy_o(busy_o),
    .done_o(done_o),
    .alu_data_o(alu_data_o),
    .zero_o(zero_o),
    .illegal_op_o(illegal_op_o)
`ifdef ALU_OVERFLOW_EN
    ,
    .overflow_o(overflow_o)
`endif
  );

  int tests = 0;
  int fails = 0;
  bit check_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] model_result(input logic [3:0] op, input logic [W-1:0] a,
                                                input logic [W-1:0] b, input int sh);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_OR:   return a | b;
      OP_SLL:  return b << sh;
      default: return '0;
    endcase
  endfunction

  function automatic bit model_illegal(input logic [3:0] op);
    return !(op == OP_ADD || op == OP_SUB || op == OP_OR || op == OP_SLL);
  endfunction

  function automatic bit model_overflow(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint s;
    longint lim;
    lim = longint'(1) << (W - 1);
    if (op == OP_ADD) s = longint'($signed(a)) + longint'($signed(b));
    else if (op == OP_SUB) s = longint'($signed(a)) - longint'($signed(b));
    else return 1'b0;
    return (s >= lim) || (s < -lim);
  endfunction

  function automatic int model_latency(input logic [3:0] op, input int sh);
    return (op == OP_SLL) ? 2 + sh : 2;
  endfunction

  logic [W-1:0] exp_q[$];
  bit           ill_q[$];
  bit           ovf_q[$];
  int           remaining = 0;
  logic         m_done = 1'b0;
  logic [W-1:0] m_data = '0;
  logic         m_zero = 1'b1;
  logic         m_ill = 1'b0;
  logic         m_ovf = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      remaining = 0;
      exp_q.delete();
      ill_q.delete();
      ovf_q.delete();
      m_done = 1'b0;
      m_data = '0;
      m_zero = 1'b1;
      m_ill  = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      m_done = 1'b0;
      if (remaining > 0) begin
        remaining--;
        if (remaining == 0) begin
          m_done = 1'b1;
          m_data = exp_q.pop_front();
          m_ill  = ill_q.pop_front();
          m_ovf  = ovf_q.pop_front();
          m_zero = (m_data == '0);
        end
      end else if (start_i) begin
        remaining = model_latency(alu_operation_i, int'(shamt_i));
        exp_q.push_back(model_result(alu_operation_i, a_data_i, b_data_i, int'(shamt_i)));
        ill_q.push_back(model_illegal(alu_operation_i));
        ovf_q.push_back(model_overflow(alu_operation_i, a_data_i, b_data_i));
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (check_en) begin
      check("busy", 64'(busy_o), 64'(remaining > 0));
      check("done", 64'(done_o), 64'(m_done));
      check("data", 64'(alu_data_o), 64'(m_data));
      check("zero", 64'(zero_o), 64'(m_zero));
      check("illegal", 64'(illegal_op_o), 64'(m_ill));
`ifdef ALU_OVERFLOW_EN
      check("overflow", 64'(overflow_o), 64'(m_ovf));
`endif
    end
  end

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic start_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic [4:0] sh);
    start_i = 1'b1;
    alu_operation_i = op;
    a_data_i = a;
    b_data_i = b;
    shamt_i = sh;
    @(negedge clk);
    start_i = 1'b0;
    alu_operation_i = 4'($urandom_range(0, 15));
    a_data_i = $urandom;
    b_data_i = $urandom;
    shamt_i = 5'($urandom_range(0, 31));
  endtask

  task automatic wait_done(input bit poke, output int cycles);
    cycles = 0;
    if (poke) begin
      start_i = 1'b1;
      alu_operation_i = OP_ADD;
      a_data_i = $urandom;
      b_data_i = $urandom;
    end
    while (1) begin
      @(negedge clk);
      start_i = 1'b0;
      cycles++;
      if (done_o) break;
      if (cycles >= 60) begin
        check("done_timeout", 64'(done_o), 64'd1);
        break;
      end
    end
  endtask

  task automatic run_directed(input string name, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input logic [4:0] sh,
                              input int exp_lat, input logic [W-1:0] exp_data, input bit exp_ill);
    int c;
    start_op(op, a, b, sh);
    wait_done(1'b0, c);
    check({name, "_latency"}, 64'(c), 64'(exp_lat));
    check({name, "_data"}, 64'(alu_data_o), 64'(exp_data));
    check({name, "_zero"}, 64'(zero_o), 64'(exp_data == '0));
    check({name, "_illegal"}, 64'(illegal_op_o), 64'(exp_ill));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c;
    int n_done;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("reset_busy", 64'(busy_o), 64'd0);
    check("reset_done", 64'(done_o), 64'd0);
    check("reset_data", 64'(alu_data_o), 64'd0);
    check("reset_zero", 64'(zero_o), 64'd1);
    check("reset_illegal", 64'(illegal_op_o), 64'd0);
    check_en = 1'b1;

    run_directed("add_5_7", OP_ADD, 32'd5, 32'd7, 5'd0, 2, 32'd12, 1'b0);
    run_directed("sub_9_9", OP_SUB, 32'd9, 32'd9, 5'd0, 2, 32'd0, 1'b0);
    run_directed("sub_0_1", OP_SUB, 32'd0, 32'd1, 5'd0, 2, 32'hFFFF_FFFF, 1'b0);
    run_directed("or", OP_OR, 32'hF0F0_0000, 32'h0000_0F0F, 5'd3, 2, 32'hF0F0_0F0F, 1'b0);
    run_directed("sll_31", OP_SLL, 32'd0, 32'd1, 5'd31, 33, 32'h8000_0000, 1'b0);
    run_directed("sll_0", OP_SLL, 32'd0, 32'hDEAD_BEEF, 5'd0, 2, 32'hDEAD_BEEF, 1'b0);
    run_directed("illegal_1001", 4'b1001, 32'd3, 32'd4, 5'd0, 2, 32'd0, 1'b1);

    // start pulsed while SLL is busy must be dropped
    start_op(OP_SLL, 32'd0, 32'd3, 5'd10);
    wait_done(1'b1, c);
    check("sll_ignore_latency", 64'(c), 64'd12);
    check("sll_ignore_data", 64'(alu_data_o), 64'd3072);
    n_done = 0;
    repeat (5) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("ignore_no_extra_done", 64'(n_done), 64'd0);

`ifdef ALU_OVERFLOW_EN
    start_op(OP_ADD, 32'h7FFF_FFFF, 32'd1, 5'd0);
    wait_done(1'b0, c);
    check("ovf_add_data", 64'(alu_data_o), 64'h8000_0000);
    check("ovf_add_flag", 64'(overflow_o), 64'd1);
    start_op(OP_OR, 32'h7FFF_FFFF, 32'h8000_0001, 5'd0);
    wait_done(1'b0, c);
    check("ovf_or_flag", 64'(overflow_o), 64'd0);
`endif

    // reset in the middle of a long shift: no completion, outputs back to reset values
    start_op(OP_SLL, 32'd0, 32'd1, 5'd20);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_busy", 64'(busy_o), 64'd0);
    check("midreset_data", 64'(alu_data_o), 64'd0);
    check("midreset_zero", 64'(zero_o), 64'd1);
    n_done = 0;
    repeat (25) begin
      @(negedge clk);
      if (done_o) n_done++;
    end
    check("midreset_no_done", 64'(n_done), 64'd0);
    run_directed("post_reset_add", OP_ADD, 32'hFFFF_FFFF, 32'd2, 5'd0, 2, 32'd1, 1'b0);

    // random traffic
    for (int i = 0; i < 150; i++) begin
      logic [3:0] op;
      logic [4:0] sh;
      int sel;
      sel = $urandom_range(0, 9);
      case (sel)
        0, 1: op = OP_ADD;
        2, 3: op = OP_SUB;
        4, 5: op = OP_OR;
        6, 7: op = OP_SLL;
        default: op = 4'($urandom_range(0, 15));
      endcase
      sh = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
      start_op(op, $urandom, ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom, sh);
      wait_done($urandom_range(0, 2) == 0, c);
      check("rand_latency", 64'(c), 64'(model_latency(op, int'(sh))));
    end

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
